// File: rtl/rx_ts_queue_if.sv
// ============================================================================
// rx_ts_queue_if : capture and read-side bundle for the rx timestamp queue
// Rev 1.0
// ============================================================================
`default_nettype none

interface rx_ts_queue_if;
    logic        cap_valid_i;
    logic [79:0] cap_timestamp_i;
    logic [15:0] cap_frac_ns_i;
    logic [3:0]  cap_messageType_i;
    logic [15:0] cap_seqId_i;
    logic [79:0] cap_sourcePortIdentity_i;
    logic        rd_req_i;
    logic        rd_valid_o;
    logic [79:0] rd_timestamp_o;
    logic [15:0] rd_frac_ns_o;
    logic [3:0]  rd_messageType_o;
    logic [15:0] rd_seqId_o;
    logic [79:0] rd_sourcePortIdentity_o;

    // The queue is the slave; the parser and host side together act as master.
    modport slave (
        input  cap_valid_i, cap_timestamp_i, cap_frac_ns_i, cap_messageType_i,
               cap_seqId_i, cap_sourcePortIdentity_i, rd_req_i,
        output rd_valid_o, rd_timestamp_o, rd_frac_ns_o, rd_messageType_o,
               rd_seqId_o, rd_sourcePortIdentity_o
    );

    modport master (
        output cap_valid_i, cap_timestamp_i, cap_frac_ns_i, cap_messageType_i,
               cap_seqId_i, cap_sourcePortIdentity_i, rd_req_i,
        input  rd_valid_o, rd_timestamp_o, rd_frac_ns_o, rd_messageType_o,
               rd_seqId_o, rd_sourcePortIdentity_o
    );
endinterface

`default_nettype wire

// File: rtl/rx_ts_queue.sv
// ============================================================================
// rx_ts_queue : FWFT multi-entry PTP receive-timestamp queue with type filter,
//               overflow policy, saturating overflow count and level interrupt
// Rev 1.0
// ============================================================================
`default_nettype none

module rx_ts_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int OVF_W = 16
) (
    input  logic             rx_clk,
    input  logic             rx_rst_n,
    input  logic             rx_clk_en_i,
    rx_ts_queue_if.slave     bus,
    input  logic [15:0]      msg_type_mask_i,
    input  logic             ovwr_mode_i,
    input  logic             clear_i,
    input  logic [AW:0]      int_thresh_i,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [OVF_W-1:0] ovf_cnt_o,
    output logic             int_o
);

    localparam int          c_EW    = 196;
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [c_EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             int_q, int_d;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic [c_EW-1:0]  w_wr_data;
    logic [c_EW-1:0]  w_head;

    always_comb begin
        w_full    = (level_q == c_DEPTH);
        w_empty   = (level_q == '0);
        w_push    = bus.cap_valid_i & msg_type_mask_i[bus.cap_messageType_i];
        w_pop     = bus.rd_req_i & ~w_empty;
        w_wr_data = {bus.cap_timestamp_i, bus.cap_frac_ns_i, bus.cap_messageType_i,
                     bus.cap_seqId_i, bus.cap_sourcePortIdentity_i};
        w_wr_en   = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        int_d     = int_q;

        if (rx_clk_en_i) begin
            if (clear_i) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                level_d  = '0;
                ovf_d    = '0;
            end else begin
                if (w_push && (!w_full || w_pop)) begin
                    w_wr_en  = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (!w_pop) begin
                        level_d = level_q + (AW+1)'(1);
                    end
                end else if (w_push) begin
                    // Full with no pop: entry is lost either way, so it always counts.
                    if (ovf_q != {OVF_W{1'b1}}) begin
                        ovf_d = ovf_q + OVF_W'(1);
                    end
                    if (ovwr_mode_i) begin
                        w_wr_en  = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end

                if (w_pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (!w_push) begin
                        level_d = level_q - (AW+1)'(1);
                    end
                end
            end
            // Interrupt follows the visible level one enabled cycle later.
            int_d = (int_thresh_i != '0) && (level_q >= int_thresh_i);
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
            int_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            int_q    <= int_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by level_q alone.
    always_ff @(posedge rx_clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= w_wr_data;
        end
    end

    always_comb begin
        w_head = w_empty ? '0 : mem_q[rd_ptr_q];
        bus.rd_valid_o              = ~w_empty;
        bus.rd_timestamp_o          = w_head[195:116];
        bus.rd_frac_ns_o            = w_head[115:100];
        bus.rd_messageType_o        = w_head[99:96];
        bus.rd_seqId_o              = w_head[95:80];
        bus.rd_sourcePortIdentity_o = w_head[79:0];
    end

    assign level_o   = level_q;
    assign full_o    = w_full;
    assign empty_o   = w_empty;
    assign ovf_cnt_o = ovf_q;
    assign int_o     = int_q;

endmodule

`default_nettype wire
